// File: rtl/spi_xfer_scheduler_pkg.sv
// Shared types and default parameters for the SPI transfer scheduler.
package spi_sched_pkg;

    localparam int DEF_NUM_REQ    = 4;
    localparam int DEF_ADDR_WIDTH = 5;
    localparam int DEF_TIMEOUT    = 1024;
    localparam int DEF_GAP        = 2;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_GRANT = 3'd1,
        S_START = 3'd2,
        S_WAIT  = 3'd3,
        S_RESP  = 3'd4,
        S_GAP   = 3'd5
    } sched_state_t;

    typedef struct packed {
        logic crc_err;
        logic timeout;
    } sched_status_t;

endpackage

// File: rtl/spi_xfer_scheduler_if.sv
// Requester handshake plus engine control bundle shared by scheduler and environment.
interface spi_xfer_scheduler_if #(
    parameter int NUM_REQ    = spi_sched_pkg::DEF_NUM_REQ,
    parameter int ADDR_WIDTH = spi_sched_pkg::DEF_ADDR_WIDTH
);
    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
    logic [NUM_REQ-1:0]            req_ready;
    logic [NUM_REQ-1:0]            rsp_valid;
    logic                          rsp_crc_err;
    logic                          rsp_timeout;
    logic                          eng_start;
    logic [ADDR_WIDTH-1:0]         eng_addr;
    logic                          eng_abort;
    logic                          eng_done;
    logic                          eng_crc_err;
    logic                          busy;
    logic [$clog2(NUM_REQ)-1:0]    owner;

    modport master (
        input  req_valid, req_addr, eng_done, eng_crc_err,
        output req_ready, rsp_valid, rsp_crc_err, rsp_timeout,
               eng_start, eng_addr, eng_abort, busy, owner
    );

    modport slave (
        output req_valid, req_addr, eng_done, eng_crc_err,
        input  req_ready, rsp_valid, rsp_crc_err, rsp_timeout,
               eng_start, eng_addr, eng_abort, busy, owner
    );
endinterface

// File: rtl/spi_xfer_scheduler_rr_pick.sv
// Rotating-priority picker: first set request at or after ptr, searching upward with wrap.
module spi_rr_pick #(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] ptr,
    output logic [$clog2(NUM_REQ)-1:0] idx,
    output logic                       found
);
    localparam int PW = $clog2(NUM_REQ);

    logic [PW:0] slot;

    // Scan from the farthest slot back to ptr so the nearest hit wins.
    always_comb begin
        idx   = ptr;
        found = |req;
        slot  = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            slot = {1'b0, ptr} + (PW + 1)'(i);
            if (int'(slot) >= NUM_REQ) slot = slot - (PW + 1)'(NUM_REQ);
            if (req[slot[PW-1:0]]) idx = slot[PW-1:0];
        end
    end
endmodule

// File: rtl/spi_xfer_scheduler.sv
// Round-robin scheduler sharing one SPI transaction engine among NUM_REQ requesters.
//   state   | meaning
//   IDLE    | waiting for any request, picks next owner
//   GRANT   | accept owner if still requesting, latch address
//   START   | launch engine, clear timeout counter
//   WAIT    | wait for eng_done or timeout expiry
//   RESP    | return status to owner
//   GAP     | enforce chip-select idle time before next grant
module spi_xfer_scheduler import spi_sched_pkg::*; #(
    parameter int NUM_REQ    = DEF_NUM_REQ,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int TIMEOUT    = DEF_TIMEOUT,
    parameter int GAP        = DEF_GAP
) (
    input logic                  clk,
    input logic                  rst,
    spi_xfer_scheduler_if.master bus
);
    localparam int OW = $clog2(NUM_REQ);
    localparam int TW = $clog2(TIMEOUT) + 1;
    localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
    localparam logic [GW-1:0] GAP_LOAD = GW'((GAP > 0) ? GAP - 1 : 0);

    sched_state_t          state, state_nxt;
    logic [OW-1:0]         ptr, ptr_nxt, owner, owner_nxt, pick_idx;
    logic                  pick_found;
    logic [ADDR_WIDTH-1:0] addr_q, addr_nxt;
    logic [TW-1:0]         tmo_cnt, tmo_nxt;
    logic [GW-1:0]         gap_cnt, gap_nxt;
    sched_status_t         status, status_nxt;
    logic [NUM_REQ-1:0]    ready_q, ready_nxt, rsp_q, rsp_nxt;
    logic                  crc_q, crc_nxt, tmo_q, tmo_flag_nxt;
    logic                  start_q, start_nxt, abort_q, abort_nxt, busy_q;

    spi_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
        .req   (bus.req_valid),
        .ptr   (ptr),
        .idx   (pick_idx),
        .found (pick_found)
    );

    always_comb begin
        state_nxt    = state;
        ptr_nxt      = ptr;
        owner_nxt    = owner;
        addr_nxt     = addr_q;
        tmo_nxt      = tmo_cnt;
        gap_nxt      = gap_cnt;
        status_nxt   = status;
        ready_nxt    = '0;
        rsp_nxt      = '0;
        crc_nxt      = 1'b0;
        tmo_flag_nxt = 1'b0;
        start_nxt    = 1'b0;
        abort_nxt    = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (pick_found) begin
                    owner_nxt = pick_idx;
                    state_nxt = S_GRANT;
                end
            end
            S_GRANT: begin
                // A withdrawn request leaves ptr alone so the same slot keeps priority.
                if (bus.req_valid[owner]) begin
                    ready_nxt[owner] = 1'b1;
                    addr_nxt         = bus.req_addr[owner*ADDR_WIDTH +: ADDR_WIDTH];
                    ptr_nxt          = (owner == OW'(NUM_REQ - 1)) ? '0 : owner + 1'b1;
                    state_nxt        = S_START;
                end else begin
                    state_nxt = S_IDLE;
                end
            end
            S_START: begin
                start_nxt  = 1'b1;
                tmo_nxt    = '0;
                status_nxt = '0;
                state_nxt  = S_WAIT;
            end
            S_WAIT: begin
                if (bus.eng_done) begin
                    status_nxt.crc_err = bus.eng_crc_err;
                    state_nxt          = S_RESP;
                end else if (tmo_cnt == TMO_LAST) begin
                    abort_nxt          = 1'b1;
                    status_nxt.timeout = 1'b1;
                    state_nxt          = S_RESP;
                end else if (tmo_cnt != '1) begin
                    tmo_nxt = tmo_cnt + 1'b1;
                end
            end
            S_RESP: begin
                rsp_nxt[owner] = 1'b1;
                crc_nxt        = status.crc_err;
                tmo_flag_nxt   = status.timeout;
                gap_nxt        = GAP_LOAD;
                state_nxt      = (GAP == 0) ? S_IDLE : S_GAP;
            end
            S_GAP: begin
                if (gap_cnt == '0) state_nxt = S_IDLE;
                else               gap_nxt   = gap_cnt - 1'b1;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            ptr     <= '0;
            owner   <= '0;
            addr_q  <= '0;
            tmo_cnt <= '0;
            gap_cnt <= '0;
            status  <= '0;
            ready_q <= '0;
            rsp_q   <= '0;
            crc_q   <= 1'b0;
            tmo_q   <= 1'b0;
            start_q <= 1'b0;
            abort_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state   <= state_nxt;
            ptr     <= ptr_nxt;
            owner   <= owner_nxt;
            addr_q  <= addr_nxt;
            tmo_cnt <= tmo_nxt;
            gap_cnt <= gap_nxt;
            status  <= status_nxt;
            ready_q <= ready_nxt;
            rsp_q   <= rsp_nxt;
            crc_q   <= crc_nxt;
            tmo_q   <= tmo_flag_nxt;
            start_q <= start_nxt;
            abort_q <= abort_nxt;
            busy_q  <= (state_nxt != S_IDLE);
        end
    end

    assign bus.req_ready   = ready_q;
    assign bus.rsp_valid   = rsp_q;
    assign bus.rsp_crc_err = crc_q;
    assign bus.rsp_timeout = tmo_q;
    assign bus.eng_start   = start_q;
    assign bus.eng_addr    = addr_q;
    assign bus.eng_abort   = abort_q;
    assign bus.busy        = busy_q;
    assign bus.owner       = owner;
endmodule

// File: doc/spi_xfer_scheduler.md
# spi_xfer_scheduler

Round-robin scheduler that shares one SPI master transaction engine (RAM read → 32-bit SPI frame with CRC-8 → RAM writeback) among several requesters. Each requester names a RAM word address. The scheduler grants one requester at a time and launches the engine. It supervises completion with a timeout and returns a per-requester response carrying the CRC/timeout status. It sits between the client logic and the SPI master top level and enforces a minimum chip-select-idle gap between frames.

## Interface
- NUM_REQ, 4, number of requesters (2..8)
- ADDR_WIDTH, 5, RAM word address width
- TIMEOUT, 1024, max cycles from eng_start to eng_done before abort (≥ 2)
- GAP, 2, idle cycles enforced after each response before the next grant (≥ 0)
- clk, input, 1, system clock; all logic on rising edge
- rst, input, 1, asynchronous active-high reset
- req_valid, input, NUM_REQ, per-requester request; held until req_ready or withdrawn
- req_addr, input, NUM_REQ*ADDR_WIDTH, packed addresses; slice i = requester i; stable while req_valid[i]
- req_ready, output, NUM_REQ, one-hot one-cycle grant/accept pulse
- rsp_valid, output, NUM_REQ, one-hot one-cycle completion pulse to owner
- rsp_crc_err, output, 1, valid with rsp_valid: engine reported CRC mismatch
- rsp_timeout, output, 1, valid with rsp_valid: transaction aborted on timeout
- eng_start, output, 1, one-cycle launch pulse to engine
- eng_addr, output, ADDR_WIDTH, RAM address; held from grant until the response cycle
- eng_abort, output, 1, one-cycle abort pulse (forces engine idle, csn high)
- eng_done, input, 1, one-cycle completion pulse from engine
- eng_crc_err, input, 1, qualified by eng_done
- busy, output, 1, high in any state except IDLE
- owner, output, $clog2(NUM_REQ), index of current or last granted requester

## Operation
- States: IDLE → GRANT → START → WAIT → RESP → GAP → IDLE. GAP is skipped when GAP = 0.
- IDLE: if any req_valid, pick the first set bit at or after ptr, searching cyclically upward. Register the pick into owner and go to GRANT.
- GRANT: if req_valid[owner] is still 1, pulse req_ready[owner], latch eng_addr from slice owner, set ptr = owner+1 mod NUM_REQ, and go to START. Otherwise (withdrawn), return to IDLE with ptr unchanged and nothing pulsed.
- START: pulse eng_start, clear the timeout counter, go to WAIT.
- WAIT: increment the counter each cycle.
  - eng_done → RESP with crc_err latched.
  - Counter reaching TIMEOUT−1 without eng_done → pulse eng_abort, set the timeout flag, go to RESP.
  - eng_done in the same cycle as expiry: done wins, no abort.
- RESP: pulse rsp_valid[owner] with the status bits. Go to GAP, loading the gap counter with GAP−1.
- GAP: count down, then go to IDLE.
- eng_done outside WAIT is ignored.
- Arithmetic: ptr wraps modulo NUM_REQ (non-power-of-2 legal). The timeout counter is $clog2(TIMEOUT)+1 bits and saturates.

## Timing
- Reset values:
  - state IDLE, ptr 0, owner 0, eng_addr 0.
  - All pulses 0 (req_ready, rsp_valid, eng_start, eng_abort), status bits 0, busy 0.
  - No abort is issued on reset; the engine shares rst.
- All outputs are registered.
- Latency: req_valid high at edge k (in IDLE) → req_ready at k+1 → eng_start at k+2.
- eng_done at edge m → rsp_valid at m+1.
- Back-to-back requests: next req_ready is no earlier than GAP+2 cycles after rsp_valid.
- rsp_crc_err and rsp_timeout are 0 whenever rsp_valid is 0.
- Reset mid-transaction: all outputs return to reset values immediately (asynchronous). The in-flight request gets no response.

## Structure
- Package spi_sched_pkg holds:
  - the state enum sched_state_t (3 bits);
  - the status struct {crc_err, timeout};
  - the default parameter constants.
- Sub-module spi_rr_pick: combinational rotate-priority picker (req vector, ptr → index, found). Instantiated once.

## Test plan
- Single request: req_valid = 0001, addr 0 → req_ready[0] at +1, eng_start at +2, eng_addr = 0. eng_done after 40 cycles with crc_err 0 → rsp_valid = 0001 one cycle later, both status bits 0.
- Fairness: all four requesting continuously, engine done after 5 cycles → grant order 0,1,2,3,0. Each grant gap ≥ GAP+2 after the prior response.
- CRC error: eng_done with eng_crc_err = 1 → rsp_crc_err = 1, rsp_timeout = 0, to the correct owner.
- Timeout: TIMEOUT = 16, no eng_done → eng_abort exactly 16 cycles after eng_start, then rsp_timeout = 1 next cycle. eng_done in the expiry cycle → no abort, normal response.
- Withdrawal: req_valid[2] drops in the GRANT cycle → no req_ready, ptr unchanged. A pending req 3 is granted next.
- Reset mid-WAIT: assert rst → all outputs 0 asynchronously. After release, a new request to requester 1 completes normally.
